// File: rtl/limit_counter.sv
`default_nettype none
// ============================================================================
// Module   : limit_counter
// Bounded up/down counter with run-time limits, variable step, wrap/saturate.
// Revision : 1.0
// ============================================================================
module limit_counter #(
    parameter int WIDTH      = 16,
    parameter int STEP_WIDTH = 8
) (
    input  logic                  clock_i,
    input  logic                  reset_n_i,
    input  logic                  clear_i,
    input  logic                  load_i,
    input  logic [WIDTH-1:0]      load_value_i,
    input  logic                  en_i,
    input  logic                  up_i,
    input  logic [STEP_WIDTH-1:0] step_i,
    input  logic [WIDTH-1:0]      lo_i,
    input  logic [WIDTH-1:0]      hi_i,
    input  logic                  wrap_i,
    output logic [WIDTH-1:0]      count_o,
    output logic                  at_lo_o,
    output logic                  at_hi_o,
    output logic                  terminal_o,
    output logic                  overflow_o,
    output logic                  cfg_err_o
);

    // Two spare bits keep count + step and count + span free of overflow.
    localparam int EW = ((STEP_WIDTH > WIDTH) ? STEP_WIDTH : WIDTH) + 2;

    logic [WIDTH-1:0] count_q, count_d;
    logic             terminal_q, terminal_d;
    logic             overflow_q, overflow_d;
    logic             w_cfg_err;
    logic             w_event;
    logic [EW-1:0]    w_cnt, w_lo, w_hi, w_step, w_span;
    logic [EW-1:0]    w_room_up, w_room_dn;

    assign w_cfg_err = (lo_i > hi_i);
    assign w_cnt     = EW'(count_q);
    assign w_lo      = EW'(lo_i);
    assign w_hi      = EW'(hi_i);
    assign w_step    = EW'(step_i);
    assign w_span    = w_hi - w_lo + EW'(1);
    assign w_room_up = w_hi - w_cnt;
    assign w_room_dn = w_cnt - w_lo;

    always_comb begin
        count_d    = count_q;
        overflow_d = overflow_q;
        w_event    = 1'b0;
        if (clear_i) begin
            count_d    = lo_i;
            overflow_d = 1'b0;
        end else if (!w_cfg_err && load_i) begin
            if (load_value_i < lo_i) begin
                count_d = lo_i;
                w_event = 1'b1;
            end else if (load_value_i > hi_i) begin
                count_d = hi_i;
                w_event = 1'b1;
            end else begin
                count_d = load_value_i;
            end
        end else if (!w_cfg_err && en_i) begin
            // Limits moved under the count: pull it back inside, no step.
            if (count_q > hi_i) begin
                count_d = hi_i;
                w_event = 1'b1;
            end else if (count_q < lo_i) begin
                count_d = lo_i;
                w_event = 1'b1;
            end else if (up_i) begin
                if (w_step <= w_room_up) begin
                    count_d = WIDTH'(w_cnt + w_step);
                end else if (wrap_i && (w_step <= w_span)) begin
                    count_d = WIDTH'(w_cnt + w_step - w_span);
                    w_event = 1'b1;
                end else begin
                    count_d = hi_i;
                    w_event = 1'b1;
                end
            end else begin
                if (w_step <= w_room_dn) begin
                    count_d = WIDTH'(w_cnt - w_step);
                end else if (wrap_i && (w_step <= w_span)) begin
                    count_d = WIDTH'(w_cnt + w_span - w_step);
                    w_event = 1'b1;
                end else begin
                    count_d = lo_i;
                    w_event = 1'b1;
                end
            end
        end
        terminal_d = w_event;
        if (w_event) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clock_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            count_q    <= '0;
            terminal_q <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            count_q    <= count_d;
            terminal_q <= terminal_d;
            overflow_q <= overflow_d;
        end
    end

    assign count_o    = count_q;
    assign at_lo_o    = (count_q == lo_i);
    assign at_hi_o    = (count_q == hi_i);
    assign terminal_o = terminal_q;
    assign overflow_o = overflow_q;
    assign cfg_err_o  = w_cfg_err;

endmodule
`default_nettype wire

// File: tb/tb_limit_counter.sv
`default_nettype none
// ============================================================================
// Module   : tb_limit_counter
// Directed vector bench for limit_counter (WIDTH = 8, STEP_WIDTH = 8).
// Revision : 1.0
// ============================================================================
module tb_limit_counter;

    localparam int W  = 8;
    localparam int SW = 8;
    localparam int NV = 28;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          clear, load, en, up, wrap;
    logic [W-1:0]  load_value, lo, hi;
    logic [SW-1:0] step;
    logic [W-1:0]  count;
    logic          at_lo, at_hi, terminal, overflow, cfg_err;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    limit_counter #(.WIDTH(W), .STEP_WIDTH(SW)) dut (
        .clock_i      (clk),
        .reset_n_i    (rst_n),
        .clear_i      (clear),
        .load_i       (load),
        .load_value_i (load_value),
        .en_i         (en),
        .up_i         (up),
        .step_i       (step),
        .lo_i         (lo),
        .hi_i         (hi),
        .wrap_i       (wrap),
        .count_o      (count),
        .at_lo_o      (at_lo),
        .at_hi_o      (at_hi),
        .terminal_o   (terminal),
        .overflow_o   (overflow),
        .cfg_err_o    (cfg_err)
    );

    typedef struct {
        logic         clr;
        logic         ld;
        logic [W-1:0] ldv;
        logic         en;
        logic         up;
        logic [SW-1:0] step;
        logic [W-1:0] lo;
        logic [W-1:0] hi;
        logic         wrap;
        logic [W-1:0] e_cnt;
        logic         e_alo;
        logic         e_ahi;
        logic         e_term;
        logic         e_ovf;
        logic         e_cfg;
    } vec_t;

    vec_t vecs[NV];

    function automatic vec_t mk(input logic c, input logic l, input int lv,
                                input logic e, input logic u, input int s,
                                input int vlo, input int vhi, input logic wr,
                                input int ec, input logic ealo, input logic eahi,
                                input logic et, input logic eo, input logic ecfg);
        vec_t v;
        v.clr = c;  v.ld = l;  v.ldv = W'(lv);  v.en = e;  v.up = u;
        v.step = SW'(s);  v.lo = W'(vlo);  v.hi = W'(vhi);  v.wrap = wr;
        v.e_cnt = W'(ec);  v.e_alo = ealo;  v.e_ahi = eahi;
        v.e_term = et;  v.e_ovf = eo;  v.e_cfg = ecfg;
        return v;
    endfunction

    task automatic check(input string name, input int actual, input int expected);
        n_checks++;
        if (actual != expected) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    task automatic drive(input vec_t v);
        clear = v.clr;  load = v.ld;  load_value = v.ldv;  en = v.en;
        up = v.up;  step = v.step;  lo = v.lo;  hi = v.hi;  wrap = v.wrap;
    endtask

    initial begin
        //               clr ld  ldv  en up stp lo   hi  wr | cnt alo ahi trm ovf cfg
        vecs[0]  = mk(0, 1,  18, 0, 0,  0, 10,  20, 1,  18, 0, 0, 0, 0, 0);
        vecs[1]  = mk(0, 0,   0, 1, 1,  5, 10,  20, 1,  12, 0, 0, 1, 1, 0);
        vecs[2]  = mk(0, 0,   0, 0, 1,  5, 10,  20, 1,  12, 0, 0, 0, 1, 0);
        vecs[3]  = mk(0, 0,   0, 1, 0,  5, 10,  20, 0,  10, 1, 0, 1, 1, 0);
        vecs[4]  = mk(0, 0,   0, 1, 0,  5, 10,  20, 0,  10, 1, 0, 1, 1, 0);
        vecs[5]  = mk(1, 0,   0, 0, 0,  0, 10,  20, 0,  10, 1, 0, 0, 0, 0);
        vecs[6]  = mk(0, 1,  15, 0, 0,  0, 10,  20, 0,  15, 0, 0, 0, 0, 0);
        vecs[7]  = mk(0, 0,   0, 1, 1,  5, 10,  20, 0,  20, 0, 1, 0, 0, 0);
        vecs[8]  = mk(0, 0,   0, 1, 1,  0, 10,  20, 0,  20, 0, 1, 0, 0, 0);
        vecs[9]  = mk(0, 0,   0, 1, 1,  1, 10,  20, 0,  20, 0, 1, 1, 1, 0);
        vecs[10] = mk(0, 0,   0, 1, 1,  1, 10,  20, 1,  10, 1, 0, 1, 1, 0);
        vecs[11] = mk(0, 0,   0, 1, 0,  1, 10,  20, 1,  20, 0, 1, 1, 1, 0);
        vecs[12] = mk(1, 0,   0, 0, 0,  0,  0,   3, 1,   0, 1, 0, 0, 0, 0);
        vecs[13] = mk(0, 1,   2, 0, 0,  0,  0,   3, 1,   2, 0, 0, 0, 0, 0);
        vecs[14] = mk(0, 0,   0, 1, 1,  9,  0,   3, 1,   3, 0, 1, 1, 1, 0);
        vecs[15] = mk(0, 0,   0, 1, 1,  2,  0,   3, 1,   1, 0, 0, 1, 1, 0);
        vecs[16] = mk(0, 1, 250, 0, 0,  0,  0, 255, 1, 250, 0, 0, 0, 1, 0);
        vecs[17] = mk(0, 0,   0, 1, 1, 10,  0, 255, 1,   4, 0, 0, 1, 1, 0);
        vecs[18] = mk(0, 0,   0, 1, 0,  5,  0, 255, 1, 255, 0, 1, 1, 1, 0);
        vecs[19] = mk(0, 0,   0, 1, 1,  1,  0, 100, 0, 100, 0, 1, 1, 1, 0);
        vecs[20] = mk(0, 0,   0, 1, 0,  1,150, 200, 0, 150, 1, 0, 1, 1, 0);
        vecs[21] = mk(1, 1, 250, 1, 1,  1, 10,  20, 0,  10, 1, 0, 0, 0, 0);
        vecs[22] = mk(0, 1, 250, 0, 0,  0, 10,  20, 0,  20, 0, 1, 1, 1, 0);
        vecs[23] = mk(0, 0,   0, 1, 1,  1, 30,  20, 0,  20, 0, 1, 0, 1, 1);
        vecs[24] = mk(0, 1,   5, 0, 0,  0, 30,  20, 0,  20, 0, 1, 0, 1, 1);
        vecs[25] = mk(1, 0,   0, 0, 0,  0, 30,  20, 0,  30, 1, 0, 0, 0, 1);
        vecs[26] = mk(0, 1,   3, 0, 0,  0, 10,  20, 0,  10, 1, 0, 1, 1, 0);
        vecs[27] = mk(0, 0,   0, 0, 0,  0, 10,  20, 0,  10, 1, 0, 0, 1, 0);

        rst_n = 1'b0;
        clear = 0; load = 0; load_value = '0; en = 0; up = 0; step = '0;
        lo = '0; hi = 8'd5; wrap = 0;
        #3;
        check("reset_count", int'(count), 0);
        check("reset_terminal", int'(terminal), 0);
        check("reset_overflow", int'(overflow), 0);
        check("reset_at_lo", int'(at_lo), 1);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < NV; i++) begin
            @(negedge clk);
            drive(vecs[i]);
            @(posedge clk);
            #1;
            check($sformatf("v%0d_count", i), int'(count), int'(vecs[i].e_cnt));
            check($sformatf("v%0d_at_lo", i), int'(at_lo), int'(vecs[i].e_alo));
            check($sformatf("v%0d_at_hi", i), int'(at_hi), int'(vecs[i].e_ahi));
            check($sformatf("v%0d_terminal", i), int'(terminal), int'(vecs[i].e_term));
            check($sformatf("v%0d_overflow", i), int'(overflow), int'(vecs[i].e_ovf));
            check($sformatf("v%0d_cfg_err", i), int'(cfg_err), int'(vecs[i].e_cfg));
        end

        // Combinational flags follow lo/hi without a clock edge.
        @(negedge clk);
        drive(mk(0, 0, 0, 0, 0, 0, 40, 10, 0, 0, 0, 0, 0, 0, 0));
        #1;
        check("comb_cfg_err", int'(cfg_err), 1);
        check("comb_at_hi", int'(at_hi), 1);
        check("comb_at_lo", int'(at_lo), 0);

        // Load 37, saturate upward, then asynchronous reset between edges.
        @(negedge clk);
        drive(mk(0, 1, 37, 0, 0, 0, 0, 255, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("pre_rst_count", int'(count), 37);
        check("pre_rst_overflow", int'(overflow), 1);
        @(negedge clk);
        drive(mk(0, 0, 0, 1, 1, 250, 0, 255, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("sat_top_count", int'(count), 255);
        check("sat_top_terminal", int'(terminal), 1);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst_count", int'(count), 0);
        check("async_rst_terminal", int'(terminal), 0);
        check("async_rst_overflow", int'(overflow), 0);

        // A pending load must not win against a held reset.
        drive(mk(0, 1, 99, 0, 0, 0, 0, 255, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk);
        #1;
        check("rst_beats_load", int'(count), 0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_edge_load", int'(count), 99);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, expected finish before 100000");
        $fatal(1, "timeout");
    end

endmodule
`default_nettype wire

// File: doc/limit_counter.md
# limit_counter

Parametrised bounded up/down counter, the general-purpose successor to the basic counter. It adds run-time lower/upper limits, a variable step size, wrap or saturate modes, synchronous clear and load, and limit-event reporting. It is used for joint position tracking, step accumulation and PWM/timebase generation in the arm controller. Count is unsigned and always kept inside [lo, hi] once any operation has executed.

## Interface
Parameters:
- WIDTH, 16, bit width of count, limits and load value
- STEP_WIDTH, 8, bit width of step input

Ports:
- clock  in  1  system clock, all state updates on rising edge
- reset_n  in  1  asynchronous, active-low reset
- clear  in  1  synchronous clear: count <= lo, overflow <= 0
- load  in  1  synchronous load of load_value (clamped)
- load_value  in  WIDTH  value for load
- en  in  1  step enable
- up  in  1  1 = add step, 0 = subtract step
- step  in  STEP_WIDTH  unsigned step magnitude
- lo  in  WIDTH  lower limit (inclusive)
- hi  in  WIDTH  upper limit (inclusive)
- wrap  in  1  1 = wrap mode, 0 = saturate mode
- count  out  WIDTH  registered count
- at_lo  out  1  combinational: count == lo
- at_hi  out  1  combinational: count == hi
- terminal  out  1  registered one-cycle pulse on a limit event
- overflow  out  1  sticky limit-event flag
- cfg_err  out  1  combinational: lo > hi

## Operation
- Priority per cycle is clear > load > en. Only one action executes per cycle.
- clear: count <= lo; overflow <= 0; terminal <= 0. Executes even when cfg_err = 1.
- load (cfg_err = 0):
  - count <= load_value clamped to [lo, hi].
  - If clamping occurred: terminal <= 1 and overflow <= 1.
  - load never clears overflow.
- en (cfg_err = 0):
  - Out-of-range start: if count > hi, count <= hi; if count < lo, count <= lo. No step is applied, and terminal and overflow are set. This covers limits changed at run time.
  - step = 0: count holds, no event.
  - Up: sum = count + step, computed in WIDTH+1 bits.
    - sum ≤ hi: count <= sum.
    - sum > hi, wrap = 1, step ≤ span: count <= sum − span.
    - Otherwise: count <= hi.
  - Down: diff = count − step, computed signed in WIDTH+2 bits.
    - diff ≥ lo: count <= diff.
    - diff < lo, wrap = 1, step ≤ span: count <= diff + span.
    - Otherwise: count <= lo.
  - span = hi − lo + 1, held in WIDTH+1 bits. Full range (lo = 0, hi = 2^WIDTH−1) gives span = 2^WIDTH.
  - A limit event is any wrap or saturation, i.e. the result crossed hi or lo. Each limit event sets terminal <= 1 and overflow <= 1.
  - Landing exactly on hi or lo is not an event.
  - Stepping beyond a limit while already at it (saturate mode) is an event on every such cycle.
- cfg_err = 1: load and en are ignored; count and overflow hold; terminal <= 0.
- Idle cycle (no clear, load or en): count and overflow hold; terminal <= 0.

## Timing
- Reset (reset_n low, asynchronous assert, takes effect without a clock edge): count = 0, terminal = 0, overflow = 0.
  - at_lo, at_hi and cfg_err are combinational, so they follow lo/hi immediately.
  - Deassertion is synchronised externally; the first action can execute on the first rising edge with reset_n high.
- Latency of clear, load and step: 1 cycle. Inputs are sampled at the rising edge; count is valid after that edge.
- terminal is asserted in the same cycle as the count value that resulted from the event, for exactly one cycle unless the next cycle also has an event.
- overflow rises together with terminal and stays high until clear or reset.
- at_lo and at_hi are decoded from the count register and the current lo/hi. No registering.
- en may be held high continuously; one step executes per cycle.
- Reset asserted mid-operation overrides everything, including a pending load or clear on the same edge.

## Test plan
- WIDTH = 8, count 37, reset_n pulsed low between edges -> count 0, terminal 0 and overflow 0 immediately, before the next edge.
- lo = 10, hi = 20, wrap = 1, count 18, en, up, step 5 -> count 12 next cycle, terminal = 1 for one cycle, overflow = 1 and held.
- lo = 10, hi = 20, wrap = 0, count 12, down, step 5 for two cycles -> count 10 then 10, terminal high both cycles, at_lo = 1.
- count 15, up, step 5, hi = 20 -> count 20, at_hi = 1, terminal = 0, overflow unchanged.
- lo = 0, hi = 3, wrap = 1, count 2, up, step 9 (step > span 4) -> count 3, terminal = 1.
- clear, load (250) and en asserted together, lo = 10 -> count 10, overflow 0.
  - Then load 250 with hi = 20 -> count 20, terminal = 1, overflow = 1.
  - Then lo = 30, hi = 20 -> cfg_err = 1; en and load have no effect; clear still gives count 30.
